// File: rtl/charaan_adc_ctrl_if.sv
// Handshake and front-end signal bundle for the flash ADC conversion sequencer.
// The master side (front-end stimulus plus result consumer) drives requests and thermo; the slave side is the sequencer.
interface charaan_adc_ctrl_if;
    logic       start;
    logic       cont;
    logic [7:0] thermo;
    logic       sh_track;
    logic       comp_latch;
    logic       busy;
    logic [2:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       bubble_err;
    logic       zero_err;

    modport master (
        output start, cont, thermo, out_ready,
        input  sh_track, comp_latch, busy, out_data, out_valid, bubble_err, zero_err
    );

    modport slave (
        input  start, cont, thermo, out_ready,
        output sh_track, comp_latch, busy, out_data, out_valid, bubble_err, zero_err
    );
endinterface

// File: rtl/charaan_adc_ctrl.sv
// Conversion sequencer for the 3-bit flash ADC: strobes S/H and comparator latch,
// encodes the thermometer word, averages 2^AVG_LOG2 codes and hands the result out on valid/ready.
module charaan_adc_ctrl #(
    parameter int SAMPLE_CYC = 2,
    parameter int SETTLE_CYC = 1,
    parameter int AVG_LOG2   = 0
) (
    input logic              clk,
    input logic              rst,
    charaan_adc_ctrl_if.slave bus
);
    localparam int         AW    = 3 + AVG_LOG2;
    localparam logic [3:0] NCONV = 4'(1 << AVG_LOG2);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] SAMPLE = 3'd1;
    localparam logic [2:0] SETTLE = 3'd2;
    localparam logic [2:0] LATCH  = 3'd3;
    localparam logic [2:0] ENCODE = 3'd4;
    localparam logic [2:0] DONE   = 3'd5;

    logic [2:0]    state;
    logic [3:0]    cnt;
    logic [3:0]    scnt;
    logic [AW-1:0] acc;
    logic [7:0]    word;
    logic [2:0]    data_q;
    logic          bub_q;
    logic          zero_q;

    logic [2:0]    code;
    logic          bub_w;
    logic          zero_w;
    logic [AW-1:0] acc_nxt;
    logic          go;

    // Highest set bit wins, so a bubbled word still yields a usable code.
    always_comb begin
        code = 3'd0;
        for (int k = 0; k < 8; k++) begin
            if (word[k]) code = 3'(k);
        end
        zero_w  = (word == 8'h00);
        bub_w   = !zero_w && (word != (8'hFF >> (3'd7 - code)));
        acc_nxt = acc + AW'(code);
    end

    // A new window opens from IDLE, or straight out of DONE on the handshake cycle.
    assign go = (bus.start || bus.cont) &&
                ((state == IDLE) || ((state == DONE) && bus.out_ready));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            scnt   <= '0;
            acc    <= '0;
            word   <= '0;
            data_q <= '0;
            bub_q  <= 1'b0;
            zero_q <= 1'b0;
        end else if (go) begin
            state  <= SAMPLE;
            cnt    <= 4'(SAMPLE_CYC - 1);
            scnt   <= '0;
            acc    <= '0;
            bub_q  <= 1'b0;
            zero_q <= 1'b0;
        end else begin
            case (state)
                SAMPLE: begin
                    if (cnt == 4'd0) begin
                        state <= SETTLE;
                        cnt   <= 4'(SETTLE_CYC - 1);
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                SETTLE: begin
                    if (cnt == 4'd0) state <= LATCH;
                    else             cnt   <= cnt - 4'd1;
                end
                LATCH: begin
                    word  <= bus.thermo;
                    state <= ENCODE;
                end
                ENCODE: begin
                    acc    <= acc_nxt;
                    scnt   <= scnt + 4'd1;
                    bub_q  <= bub_q | bub_w;
                    zero_q <= zero_q | zero_w;
                    if (scnt + 4'd1 == NCONV) begin
                        state  <= DONE;
                        data_q <= 3'(acc_nxt >> AVG_LOG2);
                    end else begin
                        state <= SAMPLE;
                        cnt   <= 4'(SAMPLE_CYC - 1);
                    end
                end
                DONE: begin
                    if (bus.out_ready) state <= IDLE;
                end
                IDLE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // S/H tracks whenever no held sample is needed, including while idle.
    assign bus.sh_track   = (state == IDLE) || (state == SAMPLE);
    assign bus.comp_latch = (state == LATCH);
    assign bus.busy       = (state != IDLE);
    assign bus.out_valid  = (state == DONE);
    assign bus.out_data   = data_q;
    assign bus.bubble_err = bub_q;
    assign bus.zero_err   = zero_q;
endmodule

// File: tb/tb_charaan_adc_ctrl.sv
// Scoreboard bench for charaan_adc_ctrl: default instance plus a 4-way averaging instance.
module tb_charaan_adc_ctrl;
    typedef struct packed {
        logic [2:0] d;
        logic       b;
        logic       z;
    } exp_t;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_pass;
    exp_t sb[$];

    charaan_adc_ctrl_if bus0 ();
    charaan_adc_ctrl_if bus1 ();

    charaan_adc_ctrl u_dut0 (.clk(clk), .rst(rst), .bus(bus0.slave));
    charaan_adc_ctrl #(.SAMPLE_CYC(2), .SETTLE_CYC(1), .AVG_LOG2(2))
        u_dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Independent reference: scan down from the top bit; contiguity via w & (w+1).
    function automatic exp_t model(input logic [7:0] w);
        exp_t e;
        logic found;
        e = '0;
        found = 1'b0;
        for (int k = 7; k >= 0; k--) begin
            if (!found && w[k]) begin
                e.d = 3'(k);
                found = 1'b1;
            end
        end
        e.z = (w == 8'h00);
        e.b = (w != 8'h00) && ((w & (w + 8'd1)) != 8'h00);
        return e;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got !== want) $display("FAIL %s: got %0h want %0h", nm, got, want);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus0.start = 0; bus0.cont = 0; bus0.thermo = 8'h00; bus0.out_ready = 0;
        bus1.start = 0; bus1.cont = 0; bus1.thermo = 8'h00; bus1.out_ready = 0;
        #2;
        n_chk++;
        if ({bus0.sh_track, bus0.comp_latch, bus0.busy, bus0.out_valid, bus0.out_data,
             bus0.bubble_err, bus0.zero_err} !== 10'b1000_000_00)
            $display("FAIL reset_outputs: got %b want 1000000000",
                {bus0.sh_track, bus0.comp_latch, bus0.busy, bus0.out_valid, bus0.out_data,
                 bus0.bubble_err, bus0.zero_err});
        else n_pass++;
        step();
        step();
        n_chk++;
        if ({bus1.sh_track, bus1.busy, bus1.out_valid} !== 3'b100)
            $display("FAIL reset_avg_inst: got %b want 100", {bus1.sh_track, bus1.busy, bus1.out_valid});
        else n_pass++;
        rst = 1'b0;
        step();
    endtask

    task automatic test_timing();
        logic [5:0] sh_w, cl_w, ov_w;
        logic [5:0] sh_g, cl_g, ov_g;
        exp_t e;
        sh_w = 6'b000011; cl_w = 6'b001000; ov_w = 6'b100000;
        bus0.thermo = 8'b0001_1111; bus0.out_ready = 0;
        e = '{d: 3'd4, b: 1'b0, z: 1'b0};
        sb.push_back(e);
        bus0.start = 1;
        step();
        bus0.start = 0;
        for (int c = 0; c < 6; c++) begin
            sh_g[c] = bus0.sh_track;
            cl_g[c] = bus0.comp_latch;
            ov_g[c] = bus0.out_valid;
            if (c < 5) step();
        end
        n_chk++;
        if (sh_g !== sh_w) $display("FAIL timing_sh_track: got %b want %b", sh_g, sh_w); else n_pass++;
        n_chk++;
        if (cl_g !== cl_w) $display("FAIL timing_comp_latch: got %b want %b", cl_g, cl_w); else n_pass++;
        n_chk++;
        if (ov_g !== ov_w) $display("FAIL timing_out_valid: got %b want %b", ov_g, ov_w); else n_pass++;
        e = sb.pop_front();
        n_chk++;
        if ({bus0.out_data, bus0.bubble_err, bus0.zero_err} !== e)
            $display("FAIL timing_result: got %b want %b", {bus0.out_data, bus0.bubble_err, bus0.zero_err}, e);
        else n_pass++;
        bus0.out_ready = 1;
        step();
        chk("timing_idle_after", {31'd0, bus0.busy}, 32'd0);
    endtask

    task automatic run_one(input string nm, input logic [7:0] w, input exp_t want);
        exp_t e;
        int   lat;
        sb.push_back(want);
        bus0.thermo = w; bus0.out_ready = 1; bus0.start = 1;
        step();
        bus0.start = 0;
        lat = 0;
        while (!bus0.out_valid && lat < 100) begin step(); lat++; end
        n_chk++;
        if (lat !== 5) $display("FAIL %s_latency: got %0d want 5", nm, lat); else n_pass++;
        e = sb.pop_front();
        n_chk++;
        if ({bus0.out_data, bus0.bubble_err, bus0.zero_err} !== e)
            $display("FAIL %s_result: got %b want %b", nm, {bus0.out_data, bus0.bubble_err, bus0.zero_err}, e);
        else n_pass++;
        step();
        n_chk++;
        if (bus0.busy !== 1'b0) $display("FAIL %s_busy_drop: got %b want 0", nm, bus0.busy); else n_pass++;
    endtask

    task automatic test_codes();
        run_one("full_scale", 8'hFF, '{d: 3'd7, b: 1'b0, z: 1'b0});
        run_one("all_zero", 8'h00, '{d: 3'd0, b: 1'b0, z: 1'b1});
        run_one("bubble", 8'b0010_0111, '{d: 3'd5, b: 1'b1, z: 1'b0});
    endtask

    task automatic test_backpressure();
        logic [2:0] held;
        int lat;
        bus0.thermo = 8'h3F; bus0.out_ready = 0; bus0.start = 1;
        step();
        bus0.start = 0;
        lat = 0;
        while (!bus0.out_valid && lat < 100) begin step(); lat++; end
        chk("bp_reach_done", {31'd0, bus0.out_valid}, 32'd1);
        held = bus0.out_data;
        chk("bp_data", {29'd0, held}, 32'd5);
        for (int c = 0; c < 10; c++) begin
            bus0.start = (c == 3);
            bus0.thermo = 8'($urandom);
            step();
            n_chk++;
            if ({bus0.out_valid, bus0.out_data, bus0.comp_latch, bus0.sh_track} !== {1'b1, held, 2'b00})
                $display("FAIL bp_hold_%0d: got %b want %b", c,
                    {bus0.out_valid, bus0.out_data, bus0.comp_latch, bus0.sh_track}, {1'b1, held, 2'b00});
            else n_pass++;
        end
        bus0.start = 0; bus0.out_ready = 1;
        step();
        chk("bp_release_idle", {30'd0, bus0.busy, bus0.out_valid}, 32'd0);
    endtask

    task automatic test_back_to_back();
        exp_t e;
        logic [7:0] w;
        logic [7:0] ones;
        int lat;
        ones = 8'hFF;
        bus0.out_ready = 1;
        w = ones >> $urandom_range(0, 8);
        bus0.thermo = w;
        sb.push_back(model(w));
        bus0.cont = 1;
        step();
        for (int r = 0; r < 6; r++) begin
            lat = 0;
            while (!bus0.out_valid && lat < 100) begin step(); lat++; end
            n_chk++;
            if (lat !== 5) $display("FAIL b2b_period_%0d: got %0d want 5", r, lat); else n_pass++;
            e = sb.pop_front();
            n_chk++;
            if ({bus0.out_data, bus0.bubble_err, bus0.zero_err} !== e)
                $display("FAIL b2b_result_%0d: got %b want %b", r,
                    {bus0.out_data, bus0.bubble_err, bus0.zero_err}, e);
            else n_pass++;
            if (r == 5) begin
                bus0.cont = 0;
            end else begin
                w = (r % 2 == 0) ? 8'($urandom) : (ones >> $urandom_range(0, 8));
                bus0.thermo = w;
                sb.push_back(model(w));
            end
            step();
        end
        chk("b2b_end_idle", {31'd0, bus0.busy}, 32'd0);
    endtask

    task automatic test_reset_mid();
        bus0.thermo = 8'hFF; bus0.out_ready = 1; bus0.start = 1;
        step();
        bus0.start = 0;
        step();
        step();
        chk("rst_mid_in_settle", {30'd0, bus0.sh_track, bus0.busy}, 32'd1);
        #3 rst = 1'b1;
        #1;
        n_chk++;
        if ({bus0.sh_track, bus0.comp_latch, bus0.busy, bus0.out_valid, bus0.out_data,
             bus0.bubble_err, bus0.zero_err} !== 10'b1000_000_00)
            $display("FAIL rst_mid_outputs: got %b want 1000000000",
                {bus0.sh_track, bus0.comp_latch, bus0.busy, bus0.out_valid, bus0.out_data,
                 bus0.bubble_err, bus0.zero_err});
        else n_pass++;
        step();
        rst = 1'b0;
        step();
        run_one("post_reset", 8'h07, '{d: 3'd2, b: 1'b0, z: 1'b0});
    endtask

    task automatic test_average();
        logic [7:0] words [4];
        exp_t e;
        int idx;
        int lat;
        words[0] = 8'h01; words[1] = 8'h03; words[2] = 8'h07; words[3] = 8'h0F;
        sb.push_back('{d: 3'd1, b: 1'b0, z: 1'b0});
        idx = 0;
        bus1.out_ready = 1; bus1.thermo = 8'h00; bus1.start = 1;
        step();
        bus1.start = 0;
        lat = 0;
        while (!bus1.out_valid && lat < 200) begin
            if (bus1.comp_latch && idx < 4) begin
                bus1.thermo = words[idx];
                idx++;
            end
            step();
            lat++;
        end
        chk("avg_latency", lat, 32'd20);
        chk("avg_latch_count", idx, 32'd4);
        e = sb.pop_front();
        n_chk++;
        if ({bus1.out_data, bus1.bubble_err, bus1.zero_err} !== e)
            $display("FAIL avg_result: got %b want %b", {bus1.out_data, bus1.bubble_err, bus1.zero_err}, e);
        else n_pass++;
        step();
        chk("avg_idle", {31'd0, bus1.busy}, 32'd0);
    endtask

    initial begin
        n_chk = 0;
        n_pass = 0;
        test_reset();
        test_timing();
        test_codes();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_average();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
